// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - mm:ss BCD up/down timer with run/pause/alarm FSM
module timer_ctrl #(
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       mode_down,
    output logic [3:0] bin0,
    output logic [3:0] bin1,
    output logic [3:0] bin2,
    output logic [3:0] bin3,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    state_t     st;
    logic       dir;
    logic [7:0] alarm_cnt;
    logic [7:0] secs;
    logic [7:0] mins;

    logic [7:0] sec_up;
    logic [7:0] min_up;
    logic [7:0] sec_dn;
    logic [7:0] min_dn;
    logic       dn_zero;
    logic       is_zero;
    logic       settable;

    // Two-digit BCD field counting 00..59 with wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return (v[7:4] == 4'd0) ? 8'h59 : {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign sec_up   = bcd_inc(secs);
    assign min_up   = (secs == 8'h59) ? bcd_inc(mins) : mins;
    assign sec_dn   = bcd_dec(secs);
    assign min_dn   = (secs == 8'h00) ? bcd_dec(mins) : mins;
    assign dn_zero  = (sec_dn == 8'h00) && (min_dn == 8'h00);
    assign is_zero  = (secs == 8'h00) && (mins == 8'h00);
    assign settable = (st == S_IDLE) || (st == S_PAUSE);

    assign bin0  = secs[3:0];
    assign bin1  = secs[7:4];
    assign bin2  = mins[3:0];
    assign bin3  = mins[7:4];
    assign state = st;

    // Each branch is the highest-priority event that actually applies in
    // the current state; ignored events fall through to lower priorities.
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_IDLE;
            secs      <= 8'h00;
            mins      <= 8'h00;
            running   <= 1'b0;
            alarm     <= 1'b0;
            dir       <= 1'b0;
            alarm_cnt <= 8'd0;
        end else if (clear) begin
            st        <= S_IDLE;
            secs      <= 8'h00;
            mins      <= 8'h00;
            running   <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= 8'd0;
        end else if (stop && st == S_RUN) begin
            st      <= S_PAUSE;
            running <= 1'b0;
        end else if (stop && st == S_ALARM) begin
            st        <= S_IDLE;
            secs      <= 8'h00;
            mins      <= 8'h00;
            alarm     <= 1'b0;
            alarm_cnt <= 8'd0;
        end else if (start && settable && !(mode_down && is_zero)) begin
            st      <= S_RUN;
            running <= 1'b1;
            dir     <= mode_down;
        end else if (tick && st == S_RUN) begin
            if (!dir) begin
                secs <= sec_up;
                mins <= min_up;
            end else begin
                secs <= sec_dn;
                mins <= min_dn;
                if (dn_zero) begin
                    st        <= S_ALARM;
                    running   <= 1'b0;
                    alarm     <= 1'b1;
                    alarm_cnt <= 8'd0;
                end
            end
        end else if (tick && st == S_ALARM) begin
            if (alarm_cnt == 8'(ALARM_SECS - 1)) begin
                st        <= S_IDLE;
                alarm     <= 1'b0;
                alarm_cnt <= 8'd0;
            end else begin
                alarm_cnt <= alarm_cnt + 8'd1;
            end
        end else if (settable) begin
            if (inc_sec)
                secs <= sec_up;
            if (inc_min)
                mins <= bcd_inc(mins);
        end
    end

endmodule
